instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator/reader side of the 512x32 instruction memory.
- Owns the PC and issues word addresses to the memory read port, which returns data one cycle after enable.
- Delivers instructions to decode over a valid/ready handshake.
- Predecodes `j` so jumps resolve locally; accepts branch redirects from execute; halts on the all-zero end-of-program word.

Parameters:
- ADDR_W, 9, memory word-address width (PC width).
- DATA_W, 32, instruction width.
- START_PC, 9'd1, PC loaded on reset (program image begins at word 1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- go  in  1  leave IDLE and begin fetching at current PC.
- mem_en  out  1  read request this cycle.
- mem_addr  out  ADDR_W  word address of request (= pc).
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts this cycle.
- if_instr  out  DATA_W  instruction word.
- if_pc  out  ADDR_W  address the instruction was fetched from.
- if_is_jump  out  1  word is a `j` already resolved in fetch; decode treats it as NOP.
- redirect_valid  in  1  taken branch (beq/ble) from execute.
- redirect_pc  in  ADDR_W  branch target word address.
- halted  out  1  HALT state indicator.

Behaviour:
- Reset:
  - pc = START_PC; state = IDLE.
  - mem_en = 0, if_valid = 0, if_instr = 0, if_pc = 0, if_is_jump = 0, halted = 0.
  - Skid entry empty; in-flight flag cleared.
  - A memory return arriving the cycle after reset is discarded.
- States:
  - IDLE: no issue. go = 1 -> RUN.
  - RUN: issue per credit rule.
  - HALT: no issue, halted = 1. Exits only on redirect_valid (-> RUN) or reset.
- Issue (RUN only):
  - mem_en = 1, mem_addr = pc, then pc <= pc + 1.
  - PC is a 9-bit wrap counter: 511 -> 0.
- Credit rule: issue only if (out_valid + skid_valid + inflight - (if_valid & if_ready)) < 2. No returned word is ever dropped.
- Return path (inflight = 1 last cycle):
  - Word goes to the output register if it is empty or being consumed and the skid is empty.
  - Otherwise it goes to the skid.
  - When the output empties, the skid moves to the output.
- Handshake:
  - if_instr, if_pc and if_is_jump are stable while if_valid & !if_ready.
  - Transfer occurs on if_valid & if_ready.
  - Back-to-back throughput is 1 instruction/cycle when there are no jumps or stalls.
- Jump predecode:
  - Trigger: returned word with opcode [31:26] = 6'b000010 (return cycle T).
  - The word is delivered with if_is_jump = 1.
  - Any issue made in cycle T is squashed (its return is ignored).
  - pc <= word[8:0]; the first target issue happens in T+1. Penalty is 1 bubble.
- Redirect (highest priority, any state except IDLE):
  - Clears the output register, skid and in-flight word, including a same-cycle return.
  - pc <= redirect_pc; state <= RUN; first issue of the target next cycle.
  - A redirect coinciding with a returned jump: the redirect wins.
- Halt:
  - Trigger: returned word == 32'h0 (not squashed).
  - The word is delivered normally; any same-cycle issue is squashed.
  - state <= HALT. Words already in the output register or skid still drain to decode.
- IDLE ignores redirect_valid. go is ignored outside IDLE.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W, DATA_W.
  - Opcode constants OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BLE = 6'b100001, OP_LW = 6'b100011, OP_SW = 6'b101011.
  - Fetch-state enum {IDLE, RUN, HALT}.
- Sub-module `fetch_skid_buffer`: one-entry output register plus one-entry skid, carrying {instr, pc, is_jump}, with a flush input.

Test Plan:
- Reset, go, if_ready = 1, memory returns addr+100 -> if_pc sequence 1, 2, 3, ... on consecutive cycles with if_instr = 101, 102, 103; pc wraps 511 -> 0.
- Hold if_ready = 0 for 5 cycles mid-stream -> at most 2 outstanding words, if_instr held stable, no loss or duplication after release.
- Word at addr 16 = 32'h0800000D (j 13) -> delivered with if_is_jump = 1; next if_pc = 13, never 17.
- redirect_valid with redirect_pc = 23 while words 10 and 11 are buffered -> 10 and 11 never delivered; next if_pc = 23.
- Word at addr 27 = 32'h0 -> delivered; halted = 1 the following cycle; mem_en stays 0; redirect to 1 resumes fetch.
- Assert reset with a request in flight -> the return is ignored; if_valid = 0; fetch restarts at pc 1 after go.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, opcode encodings and the fetch-state type.
package cpu_pkg;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BLE   = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry output register backed by a one-entry skid, so a word returning
// while decode stalls is parked instead of lost.
module fetch_skid_buffer #(
   parameter int unsigned W = 42
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         skid_valid
);

   logic         out_valid_q, out_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic [W-1:0] skid_data_q, skid_data_d;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         // Output slot frees up: the older skid word has priority over the new one.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = in_valid;
            skid_data_d  = in_data;
         end else begin
            out_valid_d = in_valid;
            if (in_valid) out_data_d = in_data;
         end
      end else if (in_valid) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign skid_valid = skid_valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the instruction memory, resolves `j`
// locally, takes branch redirects from execute and stops on an all-zero word.
module instr_fetch_unit import cpu_pkg::*; #(
   parameter int unsigned              ADDR_W   = cpu_pkg::ADDR_W,
   parameter int unsigned              DATA_W   = cpu_pkg::DATA_W,
   parameter logic [ADDR_W-1:0]        START_PC = ADDR_W'(1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              if_is_jump,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   localparam int unsigned ENTRY_W = DATA_W + ADDR_W + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
   logic              inflight_q, inflight_d;

   logic               redir, issue, ret_jump, ret_halt;
   logic [1:0]         occ;
   logic               buf_out_valid, buf_skid_valid;
   logic [ENTRY_W-1:0] buf_out_data;

   assign redir    = redirect_valid && (state_q != IDLE);
   assign ret_jump = inflight_q && (mem_rdata[DATA_W-1 -: 6] == OP_J);
   assign ret_halt = inflight_q && (mem_rdata == '0);

   // Words that will still be held after this cycle's consumption; two is the limit.
   assign occ   = 2'(buf_out_valid) + 2'(buf_skid_valid) + 2'(inflight_q)
                - 2'(buf_out_valid & if_ready);
   assign issue = (state_q == RUN) && (occ < 2'd2) && !redir;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ret_pc_d   = ret_pc_q;
      inflight_d = issue;
      mem_en     = issue;
      mem_addr   = pc_q;
      if (issue) begin
         pc_d     = pc_q + 1'b1;
         ret_pc_d = pc_q;
      end
      case (state_q)
         IDLE: if (go) state_d = RUN;
         RUN: begin
            // A same-cycle issue is squashed by clearing its in-flight flag.
            if (ret_halt) begin
               state_d    = HALT;
               inflight_d = 1'b0;
            end else if (ret_jump) begin
               pc_d       = mem_rdata[ADDR_W-1:0];
               inflight_d = 1'b0;
            end
         end
         HALT: ;
         default: state_d = IDLE;
      endcase
      if (redir) begin
         state_d    = RUN;
         pc_d       = redirect_pc;
         inflight_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= START_PC;
         ret_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ret_pc_q   <= ret_pc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_skid_buffer #(.W(ENTRY_W)) u_skid (
      .clk        (clk),
      .reset      (reset),
      .flush      (redir),
      .in_valid   (inflight_q && !redir),
      .in_data    ({mem_rdata, ret_pc_q, ret_jump}),
      .out_ready  (if_ready),
      .out_valid  (buf_out_valid),
      .out_data   (buf_out_data),
      .skid_valid (buf_skid_valid)
   );

   assign if_valid                       = buf_out_valid;
   assign {if_instr, if_pc, if_is_jump} = buf_out_data;
   assign halted                         = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, program-walking scoreboard,
// table of redirect segments and hand-written corner sequences.
module tb_instr_fetch_unit;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset, go, mem_en, if_valid, if_ready, if_is_jump;
   logic          redirect_valid, halted;
   logic [AW-1:0] mem_addr, if_pc, redirect_pc;
   logic [DW-1:0] mem_rdata, if_instr;
   logic [DW-1:0] mem [0:511];

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

   instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .START_PC(9'd1)) dut (
      .clk(clk), .reset(reset), .go(go), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .if_is_jump(if_is_jump),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
   );

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
      logic          jmp;
   } exp_t;

   typedef struct {
      logic [AW-1:0] start;
      int            n;
      int            stall_at;
      int            stall_len;
      logic          exp_halt;
   } seg_t;

   exp_t          q[$];
   seg_t          segs[5];
   int            n_checks = 0, n_pass = 0, delivered = 0, stall_issues = 0;
   logic          last_valid = 1'b0, last_jmp = 1'b0;
   logic [AW-1:0] last_pc = '0;
   logic [DW-1:0] last_instr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Architectural walk of the program: sequential, `j` goes to target, zero word ends it.
   task automatic push_stream(input logic [AW-1:0] start, input int n);
      logic [AW-1:0] p;
      exp_t          e;
      p = start;
      for (int i = 0; i < n; i++) begin
         e.pc    = p;
         e.instr = mem[p];
         e.jmp   = (mem[p][31:26] == 6'b000010);
         q.push_back(e);
         if (mem[p] == '0) break;
         p = e.jmp ? mem[p][AW-1:0] : p + 9'd1;
      end
   endtask

   // One cycle: judge the edge just taken using the inputs that were applied to it.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (!reset && !redirect_valid && last_valid) begin
         if (if_ready) begin
            delivered++;
            if (q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_xfer: got pc %0d, want no transfer", last_pc);
            end else begin
               e = q.pop_front();
               chk("xfer_pc", 32'(last_pc), 32'(e.pc));
               chk("xfer_instr", last_instr, e.instr);
               chk("xfer_jump", 32'(last_jmp), 32'(e.jmp));
            end
         end else begin
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_data", {if_instr}, last_instr);
            chk("hold_pc", 32'({if_pc, if_is_jump}), 32'({last_pc, last_jmp}));
         end
      end
      last_valid = if_valid;
      last_pc    = if_pc;
      last_instr = if_instr;
      last_jmp   = if_is_jump;
   endtask

   task automatic drain(input int budget, input int stall_at, input int stall_len, output int cyc);
      int stall_left, stall_idx;
      bit stalled_once;
      cyc = 0; stall_left = 0; stall_idx = 0; stalled_once = 0;
      delivered = 0;
      while (q.size() > 0 && cyc < budget) begin
         if (!stalled_once && delivered == stall_at) begin
            stalled_once = 1;
            stall_left   = stall_len;
            stall_idx    = 0;
         end
         if_ready = (stall_left == 0);
         step();
         cyc++;
         if (stall_left > 0) begin
            stall_idx++;
            if (stall_idx >= 2 && mem_en) stall_issues++;
            stall_left--;
         end
      end
      if_ready = 1'b0;
      if (q.size() > 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d words outstanding, want 0", q.size());
      end
   endtask

   task automatic do_redirect(input logic [AW-1:0] target);
      if_ready       = 1'b0;
      q.delete();
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_valid"}, 32'(if_valid), 32'd0);
      chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
      chk({tag, "_pc"}, 32'(if_pc), 32'd0);
      chk({tag, "_instr"}, if_instr, 32'd0);
      chk({tag, "_jump"}, 32'(if_is_jump), 32'd0);
   endtask

   initial begin
      int cyc, cnt;
      segs[0] = '{start: 9'd14,  n: 10, stall_at: 3,  stall_len: 2, exp_halt: 1'b0};
      segs[1] = '{start: 9'd500, n: 20, stall_at: 6,  stall_len: 4, exp_halt: 1'b0};
      segs[2] = '{start: 9'd12,  n: 6,  stall_at: 2,  stall_len: 4, exp_halt: 1'b0};
      segs[3] = '{start: 9'd20,  n: 10, stall_at: -1, stall_len: 0, exp_halt: 1'b1};
      segs[4] = '{start: 9'd2,   n: 5,  stall_at: 1,  stall_len: 3, exp_halt: 1'b0};

      for (int i = 0; i < 512; i++) mem[i] = 32'(i + 100);
      reset = 1'b1; go = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (3) step();
      reset = 1'b0;
      step();
      reset_checks("rst");

      // IDLE must ignore a redirect; fetch then starts at the reset PC.
      redirect_valid = 1'b1; redirect_pc = 9'd50;
      step();
      redirect_valid = 1'b0;
      step();
      chk("idle_redirect_mem_en", 32'(mem_en), 32'd0);
      push_stream(9'd1, 520);
      go = 1'b1;
      step();
      go = 1'b0;
      stall_issues = 0;
      drain(2000, 60, 5, cyc);
      chk("throughput", 32'(cyc <= 535), 32'd1);
      chk("stall_no_issue", 32'(stall_issues), 32'd0);

      mem[16] = 32'h0800000D;
      mem[27] = 32'h0;
      foreach (segs[i]) begin
         do_redirect(segs[i].start);
         push_stream(segs[i].start, segs[i].n);
         drain(200, segs[i].stall_at, segs[i].stall_len, cyc);
         repeat (2) step();
         chk("seg_halted", 32'(halted), 32'(segs[i].exp_halt));
      end

      // Buffer words 10 and 11, then redirect away: they must never reach decode.
      do_redirect(9'd10);
      repeat (4) step();
      chk("buffered_valid", 32'(if_valid), 32'd1);
      chk("buffered_pc", 32'(if_pc), 32'd10);
      do_redirect(9'd23);
      push_stream(9'd23, 10);
      drain(100, -1, 0, cyc);
      step();
      chk("halt_after_zero", 32'(halted), 32'd1);
      if_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         cnt += int'(mem_en) + int'(if_valid);
      end
      if_ready = 1'b0;
      chk("halt_quiet", 32'(cnt), 32'd0);
      do_redirect(9'd1);
      chk("resume_halted", 32'(halted), 32'd0);
      push_stream(9'd1, 8);
      drain(100, -1, 0, cyc);

      // Reset while a read is outstanding: the late return must be ignored.
      do_redirect(9'd100);
      push_stream(9'd100, 40);
      delivered = 0;
      if_ready  = 1'b1;
      cnt = 0;
      while (!(delivered >= 5 && mem_en) && cnt < 100) begin
         step();
         cnt++;
      end
      chk("inflight_setup", 32'(mem_en), 32'd1);
      q.delete();
      reset = 1'b1;
      step();
      reset    = 1'b0;
      if_ready = 1'b0;
      step();
      reset_checks("rst2");
      if_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         cnt += int'(if_valid) + int'(mem_en);
      end
      chk("rst2_quiet", 32'(cnt), 32'd0);
      if_ready = 1'b0;
      push_stream(9'd1, 6);
      go = 1'b1;
      step();
      go = 1'b0;
      drain(100, 2, 2, cyc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
